// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR flip-flop command driver.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        VERIFY = 2'd2
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Wide enough to hold the larger of the two load values without wrapping.
    function automatic int timer_width(input int pulse_w, input int timeout);
        int max_val;
        max_val = (pulse_w > timeout) ? pulse_w : timeout;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// Command handshake and status bundle between a requester and sr_ff_driver.
interface sr_ff_driver_if;
    logic req_valid;
    logic req_op;
    logic req_ready;
    logic err_clr;
    logic done;
    logic err;

    modport master (
        output req_valid, req_op, err_clr,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_op, err_clr,
        output req_ready, done, err
    );
endinterface

// File: rtl/sr_drv_timer.sv
// Loadable down-counter that saturates at zero; expire flags the last counted cycle.
module sr_drv_timer #(
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == W'(1));
endmodule

// File: rtl/sr_ff_driver.sv
// Drives a fixed-width registered S or R pulse per command and, when
// SR_DRV_VERIFY_EN is defined, confirms Q_fb and flags a sticky timeout error.
module sr_ff_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 4
) (
    input  logic           CLK,
    input  logic           RST,
    sr_ff_driver_if.slave  bus,
    input  logic           Q_fb,
    output logic           S,
    output logic           R
);
    localparam int TW = timer_width(PULSE_W, TIMEOUT);

    state_t        state, state_nxt;
    logic          target, target_nxt;
    logic          s_nxt, r_nxt;
    logic          done_q, done_nxt;
    logic          err_q, err_nxt;
    logic          ready_q, ready_nxt;
    logic          load;
    logic [TW-1:0] load_val;
    logic          expire;
    logic          noop;

    sr_drv_timer #(.W(TW)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

`ifdef SR_DRV_VERIFY_EN
    assign noop = (Q_fb == bus.req_op);
`else
    logic unused_inputs;
    assign noop          = 1'b0;
    assign unused_inputs = ^{Q_fb, bus.err_clr};
`endif

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        s_nxt      = 1'b0;
        r_nxt      = 1'b0;
        done_nxt   = 1'b0;
        ready_nxt  = 1'b0;
        load       = 1'b0;
        load_val   = '0;
`ifdef SR_DRV_VERIFY_EN
        err_nxt    = err_q & ~bus.err_clr;
`else
        err_nxt    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (bus.req_valid) begin
                    target_nxt = bus.req_op;
                    if (noop) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = DRIVE;
                        ready_nxt = 1'b0;
                        s_nxt     = (bus.req_op == OP_SET);
                        r_nxt     = (bus.req_op == OP_CLR);
                        load      = 1'b1;
                        load_val  = TW'(PULSE_W);
                    end
                end
            end
            DRIVE: begin
                if (expire) begin
`ifdef SR_DRV_VERIFY_EN
                    state_nxt = VERIFY;
                    load      = 1'b1;
                    load_val  = TW'(TIMEOUT);
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
`endif
                end else begin
                    s_nxt = (target == OP_SET);
                    r_nxt = (target == OP_CLR);
                end
            end
            VERIFY: begin
`ifdef SR_DRV_VERIFY_EN
                if (Q_fb == target) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                end else if (expire) begin
                    // A timeout overrides a coincident err_clr.
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    err_nxt   = 1'b1;
                end
`else
                state_nxt = IDLE;
                ready_nxt = 1'b1;
`endif
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            S       <= 1'b0;
            R       <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            S       <= s_nxt;
            R       <= r_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            ready_q <= ready_nxt;
        end
    end

    // The latched target only matters while a command is in flight.
    always_ff @(posedge CLK) begin
        target <= target_nxt;
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver (PULSE_W=2, TIMEOUT=4); honours SR_DRV_VERIFY_EN.
module tb_sr_ff_driver;
    import sr_drv_pkg::*;

`ifdef SR_DRV_VERIFY_EN
    localparam logic VERIFY_BUILD = 1'b1;
`else
    localparam logic VERIFY_BUILD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    logic Q_fb;
    logic S;
    logic R;

    int checks = 0;
    int passed = 0;

    sr_ff_driver_if bus ();

    sr_ff_driver #(.PULSE_W(2), .TIMEOUT(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .Q_fb (Q_fb),
        .S    (S),
        .R    (R)
    );

    always #5 CLK = ~CLK;

    // Output vector order: {S, R, done, err, req_ready}
    function automatic logic [4:0] outs();
        return {S, R, bus.done, bus.err, bus.req_ready};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic op);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        step();
        bus.req_valid = 1'b0;
    endtask

    always @(negedge CLK) begin
        checks++;
        if ((S & R) !== 1'b0) $display("FAIL sr_overlap S=%b R=%b required S&R=0", S, R);
        else passed++;
    end

    task automatic test_power_on();
        RST = 1'b1;
        step();
        step();
        checks++; if (outs() !== 5'b00001) $display("FAIL por_hold outs=%b exp=%b", outs(), 5'b00001); else passed++;
        RST = 1'b0;
        step();
        checks++; if (outs() !== 5'b00001) $display("FAIL por_release outs=%b exp=%b", outs(), 5'b00001); else passed++;
    endtask

    task automatic test_set();
        Q_fb = 1'b0;
        issue(OP_SET);
        checks++; if (outs() !== 5'b10000) $display("FAIL set_t1 outs=%b exp=%b", outs(), 5'b10000); else passed++;
        step();
        checks++; if (outs() !== 5'b10000) $display("FAIL set_t2 outs=%b exp=%b", outs(), 5'b10000); else passed++;
        step();
`ifdef SR_DRV_VERIFY_EN
        checks++; if (outs() !== 5'b00000) $display("FAIL set_t3 outs=%b exp=%b", outs(), 5'b00000); else passed++;
        Q_fb = 1'b1;
        step();
        checks++; if (outs() !== 5'b00101) $display("FAIL set_t4 outs=%b exp=%b", outs(), 5'b00101); else passed++;
`else
        checks++; if (outs() !== 5'b00101) $display("FAIL set_t3 outs=%b exp=%b", outs(), 5'b00101); else passed++;
`endif
        step();
        checks++; if (outs() !== 5'b00001) $display("FAIL set_after outs=%b exp=%b", outs(), 5'b00001); else passed++;
    endtask

`ifdef SR_DRV_VERIFY_EN
    task automatic test_timeout();
        Q_fb = 1'b1;
        issue(OP_CLR);
        checks++; if (outs() !== 5'b01000) $display("FAIL to_t1 outs=%b exp=%b", outs(), 5'b01000); else passed++;
        step();
        checks++; if (outs() !== 5'b01000) $display("FAIL to_t2 outs=%b exp=%b", outs(), 5'b01000); else passed++;
        step();
        checks++; if (outs() !== 5'b00000) $display("FAIL to_t3 outs=%b exp=%b", outs(), 5'b00000); else passed++;
        repeat (3) step();
        checks++; if (outs() !== 5'b00000) $display("FAIL to_t6 outs=%b exp=%b", outs(), 5'b00000); else passed++;
        step();
        checks++; if (outs() !== 5'b00111) $display("FAIL to_t7 outs=%b exp=%b", outs(), 5'b00111); else passed++;
        step();
        checks++; if (outs() !== 5'b00011) $display("FAIL to_sticky outs=%b exp=%b", outs(), 5'b00011); else passed++;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++; if (outs() !== 5'b00001) $display("FAIL to_err_clr outs=%b exp=%b", outs(), 5'b00001); else passed++;
        // err_clr coincident with a second timeout: the timeout must win.
        issue(OP_CLR);
        repeat (5) step();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++; if (outs() !== 5'b00111) $display("FAIL to_clr_race outs=%b exp=%b", outs(), 5'b00111); else passed++;
        step();
        checks++; if (outs() !== 5'b00011) $display("FAIL to_race_sticky outs=%b exp=%b", outs(), 5'b00011); else passed++;
    endtask
`endif

    task automatic test_reset_mid_drive();
        Q_fb = 1'b0;
        issue(OP_SET);
        checks++; if (outs() !== {1'b1, 1'b0, 1'b0, VERIFY_BUILD, 1'b0})
            $display("FAIL rst_pre outs=%b exp=%b", outs(), {1'b1, 1'b0, 1'b0, VERIFY_BUILD, 1'b0}); else passed++;
        RST = 1'b1;
        step();
        checks++; if (outs() !== 5'b00001) $display("FAIL rst_first_edge outs=%b exp=%b", outs(), 5'b00001); else passed++;
        step();
        step();
        RST = 1'b0;
        step();
        checks++; if (outs() !== 5'b00001) $display("FAIL rst_release outs=%b exp=%b", outs(), 5'b00001); else passed++;
        step();
        checks++; if (outs() !== 5'b00001) $display("FAIL rst_no_resume outs=%b exp=%b", outs(), 5'b00001); else passed++;
    endtask

    task automatic test_back_to_back();
`ifdef SR_DRV_VERIFY_EN
        Q_fb = 1'b1;
        issue(OP_SET);
        checks++; if (outs() !== 5'b00101) $display("FAIL b2b_noop outs=%b exp=%b", outs(), 5'b00101); else passed++;
`else
        Q_fb = 1'b0;
        issue(OP_SET);
        step();
        step();
        checks++; if (outs() !== 5'b00101) $display("FAIL b2b_first_done outs=%b exp=%b", outs(), 5'b00101); else passed++;
`endif
        bus.req_valid = 1'b1;
        bus.req_op    = OP_CLR;
        step();
        bus.req_valid = 1'b0;
        checks++; if (outs() !== 5'b01000) $display("FAIL b2b_r1 outs=%b exp=%b", outs(), 5'b01000); else passed++;
        step();
        checks++; if (outs() !== 5'b01000) $display("FAIL b2b_r2 outs=%b exp=%b", outs(), 5'b01000); else passed++;
        step();
`ifdef SR_DRV_VERIFY_EN
        checks++; if (outs() !== 5'b00000) $display("FAIL b2b_verify outs=%b exp=%b", outs(), 5'b00000); else passed++;
        Q_fb = 1'b0;
        step();
`endif
        checks++; if (outs() !== 5'b00101) $display("FAIL b2b_done outs=%b exp=%b", outs(), 5'b00101); else passed++;
    endtask

    task automatic test_ignore_busy();
        int last;
        last = VERIFY_BUILD ? 6 : 2;
        Q_fb = 1'b0;
        issue(OP_SET);
        for (int k = 1; k <= last; k++) begin
            checks++; if (outs() !== ((k <= 2) ? 5'b10000 : 5'b00000))
                $display("FAIL ignore_k%0d outs=%b exp=%b", k, outs(), ((k <= 2) ? 5'b10000 : 5'b00000)); else passed++;
            bus.req_valid = 1'b1;
            bus.req_op    = 1'(k & 1);
            step();
        end
        bus.req_valid = 1'b0;
        checks++; if (outs() !== {3'b001, VERIFY_BUILD, 1'b1})
            $display("FAIL ignore_end outs=%b exp=%b", outs(), {3'b001, VERIFY_BUILD, 1'b1}); else passed++;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++; if (outs() !== 5'b00001) $display("FAIL ignore_idle outs=%b exp=%b", outs(), 5'b00001); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, required summary before limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST           = 1'b1;
        Q_fb          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.err_clr   = 1'b0;
        test_power_on();
        test_set();
`ifdef SR_DRV_VERIFY_EN
        test_timeout();
`endif
        test_reset_mid_drive();
        test_back_to_back();
        test_ignore_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
